// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32I multicycle core: FSM states,
// immediate/ALU/writeback selects, instruction classes and base opcodes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_SHAMT = 3'd2,
    IMM_S     = 3'd3,
    IMM_B     = 3'd4,
    IMM_U     = 3'd5,
    IMM_J     = 3'd6
  } imm_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // Instruction class produced by the decoder and consumed by the FSM.
  typedef enum logic [3:0] {
    CLS_OP     = 4'd0,
    CLS_OP_IMM = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8,
    CLS_ILL    = 4'd9
  } cls_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Next-PC source select.
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // funct3 -> ALU operation for OP / OP-IMM. 'sub' and 'sra' carry the
  // inst[30] qualifier; the caller decides whether SUB is permitted.
  function automatic logic [3:0] f3_alu_op(input logic [2:0] f3,
                                           input logic sub,
                                           input logic sra);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decoder: classifies the IR contents and
// produces the immediate and ALU selects used during EXEC.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  cls,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        illegal_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_shift;
  logic       unused_inst;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Register and rd fields belong to the datapath, not to control.
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  // Opcode-driven classification and EXEC-phase selects.
  always_comb begin
    cls        = CLS_ILL;
    imm_sel    = IMM_NONE;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls        = CLS_OP;
        imm_sel    = is_shift ? IMM_SHAMT : IMM_NONE;
        alu_op     = f3_alu_op(funct3, inst[30], inst[30]);
        illegal_op = !((funct7 == 7'h00) || (funct7 == 7'h20));
      end
      OPC_OP_IMM: begin
        cls       = CLS_OP_IMM;
        imm_sel   = is_shift ? IMM_SHAMT : IMM_I;
        alu_b_sel = 1'b1;
        alu_op    = f3_alu_op(funct3, 1'b0, inst[30]);
      end
      OPC_LOAD: begin
        cls       = CLS_LOAD;
        imm_sel   = IMM_I;
        alu_b_sel = 1'b1;
      end
      OPC_STORE: begin
        cls       = CLS_STORE;
        imm_sel   = IMM_S;
        alu_b_sel = 1'b1;
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        imm_sel = IMM_B;
      end
      OPC_LUI: begin
        cls       = CLS_LUI;
        imm_sel   = IMM_U;
        alu_b_sel = 1'b1;
        alu_op    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        cls       = CLS_AUIPC;
        imm_sel   = IMM_U;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      OPC_JAL: begin
        cls     = CLS_JAL;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        cls       = CLS_JALR;
        imm_sel   = IMM_I;
        alu_b_sel = 1'b1;
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: RESET -> FETCH -> DECODE ->
// EXEC -> (MEM) -> (WB) -> FETCH, with TRAP on an undecodable instruction.
//
// Memory handshake: a request (imem_req / dmem_req) is held high, with a
// stable dmem_we, until the matching ready is seen in the same cycle; that
// cycle completes the access. Ready while no request is up is ignored, and
// a request is never withdrawn except by reset, which the bus must treat
// as discarding the outstanding access.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic RESET_PC_WE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_RESET  = ST_RESET;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_TRAP   = ST_TRAP;

  logic [2:0] state;
  logic [2:0] state_nxt;

  logic [3:0] dec_cls;
  logic [2:0] dec_imm_sel;
  logic       dec_a_sel;
  logic       dec_b_sel;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;

  ctrl_decode u_decode (
    .inst       (inst),
    .cls        (dec_cls),
    .imm_sel    (dec_imm_sel),
    .alu_a_sel  (dec_a_sel),
    .alu_b_sel  (dec_b_sel),
    .alu_op     (dec_alu_op),
    .illegal_op (dec_illegal)
  );

  logic is_load;
  logic is_store;
  logic is_mem;

  assign is_load  = (dec_cls == CLS_LOAD);
  assign is_store = (dec_cls == CLS_STORE);
  assign is_mem   = is_load || is_store;

  // State register: the only storage in the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (dec_cls == CLS_BRANCH) state_nxt = S_FETCH;
        else if (is_mem)           state_nxt = S_MEM;
        else                       state_nxt = S_WB;
      end
      S_MEM:    if (dmem_ready) state_nxt = is_store ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_RESET;
    endcase
  end

  // Control outputs, decoded from the current state and the IR.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    imm_sel   = IMM_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    case (state)
      S_RESET: pc_we = RESET_PC_WE;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        imm_sel   = dec_imm_sel;
        alu_a_sel = dec_a_sel;
        alu_b_sel = dec_b_sel;
        alu_op    = dec_alu_op;
        if (dec_cls == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        // A store retires here, so the PC advances in the completing cycle.
        pc_we    = is_store && dmem_ready;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (is_load)                                          wb_sel = WB_MEM;
        else if ((dec_cls == CLS_JAL) || (dec_cls == CLS_JALR)) wb_sel = WB_PC4;
        if (dec_cls == CLS_JAL)       pc_sel = PC_IMM;
        else if (dec_cls == CLS_JALR) pc_sel = PC_ALU;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl. A cycle-level plan of expected
// outputs is built per instruction from the instruction-class rules and
// compared against the DUT every cycle.
module tb_multicycle_ctrl;

  // Encodings in the order the interface lists them.
  localparam logic [2:0] ST_RESET = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;
  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_SHAMT = 3'd2,
                         IMM_S = 3'd3, IMM_B = 3'd4, IMM_U = 3'd5, IMM_J = 3'd6;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

  localparam int K_OP = 0, K_IMM = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_LUI = 5,
                 K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_BAD = 9;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic       a_sel, b_sel;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       illegal;
    logic [2:0] state;
  } outs_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        ir, dr, bt;
  } ins_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] inst;
  logic imem_ready, dmem_ready, branch_taken;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic [1:0] pc_sel;
  logic [2:0] imm_sel;
  logic alu_a_sel, alu_b_sel;
  logic [3:0] alu_op;
  logic [1:0] wb_sel;
  logic illegal;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  ins_t        in_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.imem_req = imem_req;  o.dmem_req = dmem_req; o.dmem_we = dmem_we;
    o.ir_we    = ir_we;     o.pc_we    = pc_we;    o.rf_we   = rf_we;
    o.pc_sel   = pc_sel;    o.imm_sel  = imm_sel;
    o.a_sel    = alu_a_sel; o.b_sel    = alu_b_sel;
    o.alu_op   = alu_op;    o.wb_sel   = wb_sel;
    o.illegal  = illegal;   o.state    = state_o;
    return o;
  endfunction

  function automatic ins_t rand_in(input logic [31:0] i);
    ins_t x;
    x.inst = i;
    x.ir   = 1'($urandom_range(0, 1));
    x.dr   = 1'($urandom_range(0, 1));
    x.bt   = 1'($urandom_range(0, 1));
    return x;
  endfunction

  task automatic push(input outs_t o, input ins_t x);
    exp_q.push_back(o);
    in_q.push_back(x);
  endtask

  // ---------------- reference model ----------------
  task automatic ref_decode(input logic [31:0] i, output int kind, output logic legal,
                            output logic [2:0] imm, output logic a, output logic b,
                            output logic [3:0] op);
    logic [3:0] base[8];
    logic [2:0] f3;
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = i[14:12];
    legal = 1'b1; imm = IMM_NONE; a = 1'b0; b = 1'b0; op = ALU_ADD;
    case (i[6:0])
      7'b0110011: begin
        kind  = K_OP;
        legal = (i[31:25] == 7'h00) || (i[31:25] == 7'h20);
        op    = base[f3];
        if (f3 == 3'd0 && i[30]) op = ALU_SUB;
        if (f3 == 3'd5 && i[30]) op = ALU_SRA;
        if (f3 == 3'd1 || f3 == 3'd5) imm = IMM_SHAMT;
      end
      7'b0010011: begin
        kind = K_IMM; b = 1'b1; op = base[f3];
        if (f3 == 3'd5 && i[30]) op = ALU_SRA;
        imm = (f3 == 3'd1 || f3 == 3'd5) ? IMM_SHAMT : IMM_I;
      end
      7'b0000011: begin kind = K_LOAD;  imm = IMM_I; b = 1'b1; end
      7'b0100011: begin kind = K_STORE; imm = IMM_S; b = 1'b1; end
      7'b1100011: begin kind = K_BR;    imm = IMM_B; end
      7'b0110111: begin kind = K_LUI;   imm = IMM_U; b = 1'b1; op = ALU_PASS_B; end
      7'b0010111: begin kind = K_AUIPC; imm = IMM_U; a = 1'b1; b = 1'b1; end
      7'b1101111: begin kind = K_JAL;   imm = IMM_J; end
      7'b1100111: begin kind = K_JALR;  imm = IMM_I; b = 1'b1; end
      default:    begin kind = K_BAD;   legal = 1'b0; end
    endcase
  endtask

  // Expected cycle sequence for one instruction: wi / wd wait cycles on
  // instruction / data memory, bt the branch outcome, hold cycles in TRAP.
  task automatic plan(input logic [31:0] i, input int wi, input int wd,
                      input logic bt, input int hold);
    outs_t o; ins_t x;
    int kind; logic legal; logic [2:0] imm; logic a, b; logic [3:0] op;
    ref_decode(i, kind, legal, imm, a, b, op);
    for (int k = 0; k <= wi; k++) begin
      o = '0; o.state = ST_FETCH; o.imem_req = 1'b1; o.ir_we = (k == wi);
      x = rand_in($urandom); x.ir = (k == wi);
      push(o, x);
    end
    o = '0; o.state = ST_DECODE; push(o, rand_in(i));
    if (!legal) begin
      for (int k = 0; k < hold; k++) begin
        o = '0; o.state = ST_TRAP; o.illegal = 1'b1; push(o, rand_in(i));
      end
      return;
    end
    o = '0; o.state = ST_EXEC; o.imm_sel = imm; o.a_sel = a; o.b_sel = b; o.alu_op = op;
    x = rand_in(i);
    if (kind == K_BR) begin
      o.pc_we = 1'b1; o.pc_sel = bt ? 2'd1 : 2'd0; x.bt = bt;
    end
    push(o, x);
    if (kind == K_BR) return;
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int k = 0; k <= wd; k++) begin
        o = '0; o.state = ST_MEM; o.dmem_req = 1'b1; o.dmem_we = (kind == K_STORE);
        if (k == wd && kind == K_STORE) o.pc_we = 1'b1;
        x = rand_in(i); x.dr = (k == wd);
        push(o, x);
      end
      if (kind == K_STORE) return;
    end
    o = '0; o.state = ST_WB; o.rf_we = 1'b1; o.pc_we = 1'b1;
    o.wb_sel = (kind == K_LOAD) ? 2'd1 : (kind == K_JAL || kind == K_JALR) ? 2'd2 : 2'd0;
    o.pc_sel = (kind == K_JAL) ? 2'd1 : (kind == K_JALR) ? 2'd2 : 2'd0;
    push(o, rand_in(i));
  endtask

  // ---------------- driver tasks ----------------
  // Entered #1 after a rising edge; each record covers one clock cycle.
  task automatic run_n(input int n, input string tag);
    ins_t x; outs_t e;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      x = in_q.pop_front();
      e = outs_t'(exp_q.pop_front());
      inst = x.inst; imem_ready = x.ir; dmem_ready = x.dr; branch_taken = x.bt;
      #3;
      check($sformatf("%s st%0d", tag, e.state), 32'(sample()), 32'(e));
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag);
    run_n(exp_q.size(), tag);
  endtask

  task automatic do_reset();
    outs_t o;
    exp_q.delete(); in_q.delete();
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'(sample()), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    o = '0; o.state = ST_RESET;
    push(o, rand_in($urandom));
  endtask

  function automatic logic known_opc(input logic [6:0] c);
    return c == 7'b0110011 || c == 7'b0010011 || c == 7'b0000011 || c == 7'b0100011 ||
           c == 7'b1100011 || c == 7'b0110111 || c == 7'b0010111 || c == 7'b1101111 ||
           c == 7'b1100111;
  endfunction

  task automatic gen(output logic [31:0] i);
    logic [31:0] r;
    logic [6:0] opcs[9];
    int c;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    r = $urandom;
    c = $urandom_range(0, 10);
    if (c == 0)      i = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r[24:7], 7'b0110011};
    else if (c < 9)  i = {r[31:7], opcs[c]};
    else if (c == 9) i = {r[31:25] | 7'h01, r[24:7], 7'b0110011};
    else begin
      i = {r[31:7], 7'h7f};
      for (int t = 0; t < 50; t++) begin
        r = $urandom;
        if (!known_opc(r[6:0])) begin i = r; break; end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] i;
    int kind; logic legal; logic [2:0] imm; logic a, b; logic [3:0] op;
    rst_n = 1'b0; inst = '0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    do_reset();

    plan(32'h00500093, 0, 0, 1'b0, 0); run("addi");
    plan(32'h0000A103, 0, 3, 1'b0, 0); run("lw_wait3");
    plan(32'h00208463, 0, 0, 1'b1, 0); run("beq_taken");
    plan(32'h00208463, 0, 0, 1'b0, 0); run("beq_not");
    plan(32'h00309093, 0, 0, 1'b0, 0); run("slli");
    plan(32'h4030D093, 0, 0, 1'b0, 0); run("srai");
    plan(32'h40208133, 1, 0, 1'b0, 0); run("sub");

    for (int n = 0; n < 150; n++) begin
      gen(i);
      ref_decode(i, kind, legal, imm, a, b, op);
      plan(i, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(1, 6));
      run("rand");
      if (!legal) do_reset();
    end

    plan(32'hFFFFFFFF, 0, 0, 1'b0, 20); run("trap");

    // Reset pulsed in the middle of a stalled store.
    do_reset();
    plan(32'h0020A023, 0, 8, 1'b0, 0);
    run_n(5, "sw_abort");
    #2;
    do_reset();
    plan(32'h00500093, 0, 0, 1'b0, 0); run("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives the immediate-generator select, ALU operand/op selects, PC/IR/register-file write enables and the instruction/data memory request handshakes. Sits beside the datapath and consumes the IR contents and the branch comparator result.

## Interface
- `RESET_PC_WE`, default 0: if 1, assert `pc_we` with `pc_sel`=0 in the RESET state.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `inst`  in  32  current IR contents; stable except on `ir_we`
- `imem_ready`  in  1  instruction memory completes the request this cycle
- `dmem_ready`  in  1  data memory completes the request this cycle
- `branch_taken`  in  1  comparator result for `inst[14:12]`
- `imem_req`  out  1  instruction fetch request
- `dmem_req`, `dmem_we`  out  1 each  data request; write strobe
- `ir_we`, `pc_we`, `rf_we`  out  1 each  IR, PC and register-file write enables
- `pc_sel`  out  2  0 PC+4, 1 PC+imm, 2 ALU result with bit 0 cleared
- `imm_sel`  out  3  NONE, I, SHAMT, S, B, U, J
- `alu_a_sel`  out  1  0 rs1, 1 PC
- `alu_b_sel`  out  1  0 rs2, 1 immediate
- `alu_op`  out  4  ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
- `wb_sel`  out  2  0 ALU, 1 memory, 2 PC+4
- `illegal`  out  1  high while in TRAP
- `state_o`  out  3  current state, for debug

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- RESET:
  - All outputs are 0 (except `pc_we` when `RESET_PC_WE`=1).
  - Always moves to FETCH on the next edge.
- FETCH:
  - `imem_req`=1 until `imem_ready`.
  - In the `imem_ready` cycle: `ir_we`=1, then go to DECODE.
- DECODE:
  - Lasts one cycle; the register file is read.
  - Unsupported opcode, or OP funct7 not 0x00/0x20 → TRAP.
  - Otherwise → EXEC.
- EXEC: `imm_sel`, `alu_a_sel`, `alu_b_sel` and `alu_op` follow the opcode.
  - OP or OP-IMM:
    - funct3 001/101 use `imm_sel`=SHAMT.
    - SRA/SRAI are selected by `inst[30]`.
    - SUB is selected by `inst[30]` for OP only.
  - LUI: U immediate, PASS_B.
  - AUIPC: U immediate, a=PC, ADD.
  - LOAD/STORE: ADD, b=imm, I or S immediate → MEM.
  - BRANCH:
    - `imm_sel`=B, `pc_we`=1, `pc_sel`=`branch_taken` ? 1 : 0 → FETCH.
  - JAL: J immediate → WB.
  - JALR: I immediate, ADD → WB.
  - All other classes → WB.
- MEM:
  - `dmem_req`=1 until `dmem_ready`; `dmem_we`=1 for STORE.
  - On ready: LOAD → WB; STORE → FETCH with `pc_we`=1, `pc_sel`=0.
- WB:
  - `rf_we`=1 and `pc_we`=1, then → FETCH.
  - `wb_sel`: memory for LOAD, PC+4 for JAL/JALR, else ALU.
  - `pc_sel`: 1 for JAL, 2 for JALR, else 0.
- TRAP: `illegal`=1, all other outputs 0; the state holds until reset.
- A write to x0 is not suppressed here; the register file ignores it.

## Timing
- State register is the only storage. Outputs are combinational from state and `inst`; there are no registered outputs.
- Latency with zero-wait memory (ready tied 1):
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Ready in the same cycle as the request completes the access in that cycle.
- Ready while not requesting is ignored.
- Requests stay asserted, with stable `dmem_we`, until ready; there is no request withdrawal.
- `rst_n` low at any time (including mid-MEM) forces RESET asynchronously. All outputs drop to 0 in the same cycle.
- The bus side must discard an outstanding request when reset is asserted.

## Structure
- Shared package `rv_ctrl_pkg` contains:
  - the `state_e`, `imm_sel_e`, `alu_op_e` and `wb_sel_e` enums;
  - opcode constants for OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
- The immediate generator imports `imm_sel_e` from the same package.
- One sub-module, `ctrl_decode`: combinational; maps `inst` to class, `imm_sel`, `alu_op` and `illegal_op`. The FSM stays in `multicycle_ctrl`.

## Test plan
- Reset and release:
  - `rst_n`=0 → all outputs 0, `state_o`=RESET.
  - Release → cycle 1 FETCH with `imem_req`=1.
- ADDI x1,x0,5 (0x00500093), ready tied 1:
  - EXEC: `imm_sel`=I, `alu_b_sel`=1, `alu_op`=ADD.
  - Cycle 4: `rf_we`=1, `pc_we`=1, `pc_sel`=0.
- LW x2,0(x1) (0x0000A103) with `dmem_ready` delayed 3 cycles:
  - `dmem_req` is high for 4 cycles with `dmem_we`=0.
  - WB has `wb_sel`=1; total is 8 cycles.
- BEQ x1,x2,8 (0x00208463):
  - `branch_taken`=1 → EXEC `pc_we`=1, `pc_sel`=1, next FETCH.
  - `branch_taken`=0 → `pc_sel`=0.
- Shifts:
  - SLLI (0x00309093) → `imm_sel`=SHAMT, `alu_op`=SLL.
  - SRAI (0x4030D093) → `alu_op`=SRA.
- Illegal instruction and reset abort:
  - 0xFFFFFFFF → TRAP, `illegal`=1, no `imem_req` for 20 cycles.
  - `rst_n` pulsed while in MEM → `dmem_req` drops immediately; after release, FETCH resumes.
